vga_sync_receiver: RTL and testbench
====================================

Name: vga_sync_receiver

Overview:
- Receive-side counterpart of the VGA timing generator. Takes active-low hsync/vsync and 4-bit RGB in the same clock domain.
- Recovers pixel coordinates and qualifies the stream with a lock state machine. Counts frames and timing errors.
- Used for loopback checking of the screensaver output and as a capture front-end for on-chip pixel checkers.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync low width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync low width (lines)
V_BACK, 33, vertical back porch (lines)
LOCK_LINES, 4, consecutive good lines required before lock

Ports:
clk  input  1  pixel clock
rst  input  1  synchronous active-high reset
hsync  input  1  active-low horizontal sync
vsync  input  1  active-low vertical sync
r  input  4  red in
g  input  4  green in
b  input  4  blue in
locked  output  1  stream qualified
visible  output  1  registered sample is in the active area and locked=1
position_x  output  $clog2(H_VISIBLE)  column of registered sample
position_y  output  $clog2(V_VISIBLE)  row of registered sample
pix_r  output  4  red, zeroed when !visible
pix_g  output  4  green, zeroed when !visible
pix_b  output  4  blue, zeroed when !visible
frame  output  32  frames received while locked
sync_error  output  1  one-cycle pulse on loss of lock
error_count  output  8  saturating count of lock losses

Behaviour:
Terms:
- WHOLE_LINE = H_VISIBLE + H_FRONT + H_SYNC + H_BACK.
- WHOLE_FRAME = V_VISIBLE + V_FRONT + V_SYNC + V_BACK.
- hfall: hsync=0 this cycle and hsync=1 last cycle. vfall is defined the same way for vsync.
- The previous-sample registers reset to 1, so sync held low through reset gives no edge.

Counters:
- Internal hc (clog2(WHOLE_LINE) bits) and vc (clog2(WHOLE_FRAME) bits) give the coordinate of the current input sample.
- On hfall the sample's hc = H_VISIBLE+H_FRONT. Otherwise hc = previous hc + 1, wrapping WHOLE_LINE-1 → 0.
- vc increments only on the hc wrap, wrapping WHOLE_FRAME-1 → 0.
- On vfall the sample's vc = V_VISIBLE+V_FRONT, and this overrides the increment.

Output timing:
- All outputs are registered with latency 1: outputs in cycle n+1 describe the input in cycle n.
- position_x = hc and position_y = vc, truncated to port width.
- visible = locked && hc<H_VISIBLE && vc<V_VISIBLE.

Line checks:
- lcnt counts clocks since the last hfall. wcnt counts consecutive hsync-low clocks.
- A line is good when, at hfall, lcnt==WHOLE_LINE and the last low pulse width was H_SYNC.
- The width is latched at the hsync rising edge.

FSM states: SEARCH, H_ACQ, LOCKED.
- SEARCH: on the first hfall → H_ACQ, with good_lines=0.
- H_ACQ:
  - Each later hfall: good line → good_lines+1, saturating at LOCK_LINES; bad line → good_lines=0.
  - On vfall with good_lines≥LOCK_LINES → LOCKED and frame=0. Otherwise stay.
- LOCKED:
  - Any of the following → SEARCH, with sync_error=1 for one cycle and error_count+1 (saturating at 255):
    - a bad line at hfall;
    - vfall where the predicted hc≠0 or the predicted vc≠V_VISIBLE+V_FRONT;
    - lcnt reaching 2*WHOLE_LINE with no hfall (timeout).
  - Otherwise, each vfall increments frame. frame wraps at 2^32.
- Simultaneous hfall and vfall in LOCKED: evaluate the line check first. On failure vfall is ignored and frame is not incremented.
- locked=1 exactly when the registered state is LOCKED.

Reset:
- Values: state=SEARCH, locked=0, visible=0, position_x=0, position_y=0, pix_*=0, frame=0, sync_error=0, error_count=0, hc=0, vc=0, counters=0.
- A mid-stream reset aborts any state in one cycle. error_count is not incremented.

Test Plan:
1. Drive from video_timer (default params) and release both resets together; call the first cycle k=0 → first hfall at k=720, vfall at k=417664; locked=1, frame=0 from k=417665.
2. Locked, one full frame later → frame=1. A sample with x=639, y=479 gives position_x=639, position_y=479, visible=1, pix_*=input next cycle. Sample x=640 → visible=0, pix_*=0.
3. Locked, stretch one line to 801 clocks → sync_error pulse, error_count=1, locked=0 next cycle. Clean stream resumes → relock at next vfall after ≥4 good lines.
4. Locked, shorten one hsync pulse to 95 clocks → loss of lock at the following hfall, error_count=1.
5. Locked, hold hsync high for 1600 clocks → timeout loss of lock, error_count=1. 300 forced losses → error_count=255.
6. Assert rst for 1 cycle while locked → next cycle all outputs at reset values. Stream continues → relock at next vfall.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// Receive-side VGA timing recovery: rebuilds pixel coordinates from hsync/vsync,
// qualifies the stream with a lock FSM and counts frames and lock losses.
module vga_sync_receiver #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int LOCK_LINES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hsync,
    input  logic                         vsync,
    input  logic [3:0]                   r,
    input  logic [3:0]                   g,
    input  logic [3:0]                   b,
    output logic                         locked,
    output logic                         visible,
    output logic [$clog2(H_VISIBLE)-1:0] position_x,
    output logic [$clog2(V_VISIBLE)-1:0] position_y,
    output logic [3:0]                   pix_r,
    output logic [3:0]                   pix_g,
    output logic [3:0]                   pix_b,
    output logic [31:0]                  frame,
    output logic                         sync_error,
    output logic [7:0]                   error_count
);
    localparam int WHOLE_LINE  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int WHOLE_FRAME = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HCW = $clog2(WHOLE_LINE);
    localparam int VCW = $clog2(WHOLE_FRAME);
    localparam int PXW = $clog2(H_VISIBLE);
    localparam int PYW = $clog2(V_VISIBLE);
    localparam int LCW = $clog2(2 * WHOLE_LINE + 1);
    localparam int GLW = $clog2(LOCK_LINES + 1);

    localparam logic [HCW-1:0] HC_LAST  = HCW'(WHOLE_LINE - 1);
    localparam logic [HCW-1:0] HC_SYNC  = HCW'(H_VISIBLE + H_FRONT);
    localparam logic [HCW-1:0] HC_VIS   = HCW'(H_VISIBLE);
    localparam logic [VCW-1:0] VC_LAST  = VCW'(WHOLE_FRAME - 1);
    localparam logic [VCW-1:0] VC_SYNC  = VCW'(V_VISIBLE + V_FRONT);
    localparam logic [VCW-1:0] VC_VIS   = VCW'(V_VISIBLE);
    localparam logic [LCW-1:0] LC_LINE  = LCW'(WHOLE_LINE);
    localparam logic [LCW-1:0] LC_MAX   = LCW'(2 * WHOLE_LINE);
    localparam logic [LCW-1:0] W_SYNC   = LCW'(H_SYNC);
    localparam logic [GLW-1:0] GL_TGT   = GLW'(LOCK_LINES);

    typedef enum logic [1:0] {SEARCH, H_ACQ, LOCKED} state_t;
    state_t state;

    logic           hs_q, vs_q;
    logic [HCW-1:0] hc, hc_cur;
    logic [VCW-1:0] vc, vc_pred, vc_cur;
    logic [LCW-1:0] lcnt, wcnt, width;
    logic [GLW-1:0] good_lines;
    logic           hfall, vfall, hrise;
    logic           line_good, timeout, vbad, fault, acq_done, lock_next, vis_next;

    assign hfall = hs_q & ~hsync;
    assign vfall = vs_q & ~vsync;
    assign hrise = ~hs_q & hsync;

    // Coordinates of the sample on the inputs this cycle; vc_pred is what the
    // free-running count expects before any vsync re-alignment.
    always_comb begin
        hc_cur  = hfall ? HC_SYNC : ((hc == HC_LAST) ? '0 : hc + HCW'(1));
        vc_pred = vc;
        if (!hfall && hc == HC_LAST)
            vc_pred = (vc == VC_LAST) ? '0 : vc + VCW'(1);
        vc_cur = vfall ? VC_SYNC : vc_pred;
    end

    always_comb begin
        line_good = (lcnt == LC_LINE) && (width == W_SYNC);
        timeout   = (lcnt == LC_MAX) && !hfall;
        vbad      = vfall && ((hc_cur != '0) || (vc_pred != VC_SYNC));
        fault     = (hfall && !line_good) || vbad || timeout;
        acq_done  = vfall && (good_lines >= GL_TGT);
        lock_next = ((state == LOCKED) && !fault) || ((state == H_ACQ) && acq_done);
        vis_next  = lock_next && (hc_cur < HC_VIS) && (vc_cur < VC_VIS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEARCH;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            hc          <= '0;
            vc          <= '0;
            lcnt        <= '0;
            wcnt        <= '0;
            width       <= '0;
            good_lines  <= '0;
            locked      <= 1'b0;
            visible     <= 1'b0;
            position_x  <= '0;
            position_y  <= '0;
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
            frame       <= '0;
            sync_error  <= 1'b0;
            error_count <= '0;
        end else begin
            hs_q <= hsync;
            vs_q <= vsync;
            hc   <= hc_cur;
            vc   <= vc_cur;

            if (hfall)
                lcnt <= LCW'(1);
            else if (lcnt != LC_MAX)
                lcnt <= lcnt + LCW'(1);

            if (!hsync)
                wcnt <= hfall ? LCW'(1) : ((wcnt == LC_MAX) ? wcnt : wcnt + LCW'(1));
            if (hrise)
                width <= wcnt;

            sync_error <= 1'b0;
            case (state)
                SEARCH: begin
                    if (hfall) begin
                        state      <= H_ACQ;
                        good_lines <= '0;
                    end
                end
                H_ACQ: begin
                    if (hfall)
                        good_lines <= !line_good ? '0 :
                                      (good_lines == GL_TGT) ? good_lines : good_lines + GLW'(1);
                    if (acq_done) begin
                        state <= LOCKED;
                        frame <= '0;
                    end
                end
                LOCKED: begin
                    // A failed line check masks a coincident vsync edge.
                    if (fault) begin
                        state      <= SEARCH;
                        sync_error <= 1'b1;
                        if (error_count != 8'hFF)
                            error_count <= error_count + 8'd1;
                    end else if (vfall) begin
                        frame <= frame + 32'd1;
                    end
                end
                default: state <= SEARCH;
            endcase

            locked     <= lock_next;
            visible    <= vis_next;
            position_x <= hc_cur[PXW-1:0];
            position_y <= vc_cur[PYW-1:0];
            pix_r      <= vis_next ? r : 4'd0;
            pix_g      <= vis_next ? g : 4'd0;
            pix_b      <= vis_next ? b : 4'd0;
        end
    end
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a shrunken 16x12 raster so that
// lock, loss, timeout, saturation and reset scenarios fit in a short run.
module tb_vga_sync_receiver;
    localparam int HV = 8, HF = 2, HS = 4, HB = 2;
    localparam int VV = 6, VF = 2, VS = 2, VB = 2;
    localparam int LL = 4;
    localparam int WL = HV + HF + HS + HB;
    localparam int WF = VV + VF + VS + VB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [3:0]  r = '0, g = '0, b = '0;
    logic        locked, visible, sync_error;
    logic [$clog2(HV)-1:0] position_x;
    logic [$clog2(VV)-1:0] position_y;
    logic [3:0]  pix_r, pix_g, pix_b;
    logic [31:0] frame;
    logic [7:0]  error_count;

    vga_sync_receiver #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .LOCK_LINES(LL)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b),
        .locked(locked), .visible(visible),
        .position_x(position_x), .position_y(position_y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .frame(frame), .sync_error(sync_error), .error_count(error_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Raster generator state and one-shot disturbances.
    int gx = 0, gy = 0, sx = 0, sy = 0;
    int extra = 0;
    bit short_pulse = 1'b0;
    int mask_lo = -1, mask_hi = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one raster sample, clock it in, and return #1 after the edge so
    // the outputs describe exactly that sample (sx, sy).
    task automatic gen_cycle();
        logic hs, vs;
        hs = !(gx >= HV + HF && gx < HV + HF + HS);
        if (short_pulse && gx == HV + HF + HS - 1) begin
            hs = 1'b1;
            short_pulse = 1'b0;
        end
        if (gy >= mask_lo && gy <= mask_hi) hs = 1'b1;
        vs = !(gy >= VV + VF && gy < VV + VF + VS);
        hsync = hs;
        vsync = vs;
        r = 4'(gx);
        g = 4'(gy);
        b = 4'ha;
        sx = gx;
        sy = gy;
        if (gx == WL - 1 && extra > 0) extra--;
        else if (gx == WL - 1) begin
            gx = 0;
            gy = (gy == WF - 1) ? 0 : gy + 1;
        end else gx++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int x, input int y, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            gen_cycle();
            if (sx == x && sy == y) found = 1'b1;
        end
        check({tag, "_reach"}, 32'(found), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_visible", 32'(visible), 32'd0);
        check("rst_frame", frame, 32'd0);
        check("rst_errcnt", 32'(error_count), 32'd0);
        check("rst_syncerr", 32'(sync_error), 32'd0);
        check("rst_posx", 32'(position_x), 32'd0);
        rst = 1'b0;

        // Initial acquisition: hfall at (10,0), four good lines, lock at vfall (0,8).
        run_until(15, 7, "acq");
        check("acq_not_locked", 32'(locked), 32'd0);
        run_until(0, 8, "lock1");
        check("lock1_locked", 32'(locked), 32'd1);
        check("lock1_frame", frame, 32'd0);

        // Last visible pixel, then first blanked pixel.
        run_until(7, 5, "lastpix");
        check("lastpix_x", 32'(position_x), 32'd7);
        check("lastpix_y", 32'(position_y), 32'd5);
        check("lastpix_vis", 32'(visible), 32'd1);
        check("lastpix_r", 32'(pix_r), 32'd7);
        check("lastpix_g", 32'(pix_g), 32'd5);
        check("lastpix_b", 32'(pix_b), 32'ha);
        gen_cycle();
        check("blank_vis", 32'(visible), 32'd0);
        check("blank_r", 32'(pix_r), 32'd0);
        check("blank_b", 32'(pix_b), 32'd0);
        run_until(0, 8, "frame1");
        check("frame1_cnt", frame, 32'd1);
        check("frame1_locked", 32'(locked), 32'd1);

        // Line 0 stretched to 17 clocks: loss at hfall (10,1).
        run_until(0, 0, "stretch");
        extra = 1;
        run_until(9, 1, "stretch_pre");
        check("stretch_pre_locked", 32'(locked), 32'd1);
        gen_cycle();
        check("stretch_syncerr", 32'(sync_error), 32'd1);
        check("stretch_locked", 32'(locked), 32'd0);
        check("stretch_errcnt", 32'(error_count), 32'd1);
        gen_cycle();
        check("stretch_pulse_end", 32'(sync_error), 32'd0);
        run_until(15, 7, "stretch_acq");
        check("stretch_acq_locked", 32'(locked), 32'd0);
        run_until(0, 8, "stretch_relock");
        check("stretch_relock", 32'(locked), 32'd1);
        check("stretch_relock_frame", frame, 32'd0);

        // 3-clock hsync pulse in line 9: loss at hfall (10,10).
        run_until(0, 9, "short");
        short_pulse = 1'b1;
        run_until(9, 10, "short_pre");
        check("short_pre_locked", 32'(locked), 32'd1);
        gen_cycle();
        check("short_syncerr", 32'(sync_error), 32'd1);
        check("short_locked", 32'(locked), 32'd0);
        check("short_errcnt", 32'(error_count), 32'd2);
        run_until(0, 8, "short_relock");
        check("short_relock", 32'(locked), 32'd1);

        // hsync held high through lines 1-2: timeout 32 clocks after hfall (10,0).
        run_until(0, 0, "tmo");
        mask_lo = 1;
        mask_hi = 2;
        run_until(9, 2, "tmo_pre");
        check("tmo_pre_locked", 32'(locked), 32'd1);
        gen_cycle();
        check("tmo_syncerr", 32'(sync_error), 32'd1);
        check("tmo_locked", 32'(locked), 32'd0);
        check("tmo_errcnt", 32'(error_count), 32'd3);
        run_until(15, 2, "tmo_end");
        mask_lo = -1;
        mask_hi = -1;
        run_until(0, 8, "tmo_relock");
        check("tmo_relock", 32'(locked), 32'd1);

        // 253 more forced losses take the counter past 255.
        for (int i = 0; i < 253; i++) begin
            run_until(0, 9, "sat_brk");
            short_pulse = 1'b1;
            run_until(0, 8, "sat_lock");
        end
        check("sat_errcnt", 32'(error_count), 32'd255);
        check("sat_locked", 32'(locked), 32'd1);

        // Mid-stream reset while locked and visible.
        run_until(0, 8, "pre_rst");
        check("pre_rst_frame", frame, 32'd1);
        run_until(4, 3, "pre_rst_pix");
        check("pre_rst_vis", 32'(visible), 32'd1);
        rst = 1'b1;
        gen_cycle();
        rst = 1'b0;
        check("mrst_locked", 32'(locked), 32'd0);
        check("mrst_visible", 32'(visible), 32'd0);
        check("mrst_posx", 32'(position_x), 32'd0);
        check("mrst_posy", 32'(position_y), 32'd0);
        check("mrst_pix_r", 32'(pix_r), 32'd0);
        check("mrst_frame", frame, 32'd0);
        check("mrst_errcnt", 32'(error_count), 32'd0);
        check("mrst_syncerr", 32'(sync_error), 32'd0);
        run_until(15, 7, "mrst_acq");
        check("mrst_acq_locked", 32'(locked), 32'd0);
        run_until(0, 8, "mrst_relock");
        check("mrst_relock", 32'(locked), 32'd1);
        check("mrst_relock_frame", frame, 32'd0);
        check("mrst_relock_errcnt", 32'(error_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
